// File: rtl/cm_pkg.sv
// Shared definitions for the tt_um_cm_1 serial front end: receiver states,
// character geometry and the 3-sample majority vote.
package cm_pkg;

   localparam int UART_DATA_BITS       = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 87;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      WAIT_HI = 3'd4
   } state_e;

   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/cm_sync_maj.sv
// Two-flop synchroniser for an asynchronous input pin followed by a
// 3-sample majority filter; everything resets to the idle-high level.
module cm_sync_maj
   import cm_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic rx_i,
   output logic rx_s,
   output logic maj
);

   logic       meta_r;
   logic       sync_r;
   logic [2:0] hist_r;

   // Synchroniser stages and the history of synchronised samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_r <= 1'b1;
         sync_r <= 1'b1;
         hist_r <= 3'b111;
      end else begin
         meta_r <= rx_i;
         sync_r <= meta_r;
         hist_r <= {hist_r[1:0], sync_r};
      end
   end

   assign rx_s = sync_r;
   assign maj  = maj3(hist_r);

endmodule

// File: rtl/cm_uart_rx.sv
// 8N1 UART receiver: deframes the filtered line and hands each byte to the
// core over valid/ready, flagging framing errors and overruns.
module cm_uart_rx
   import cm_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   input  logic       ovr_clr_i,
   output logic       busy_o
);

   localparam int               IDX_W    = $clog2(UART_DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

   logic                      rx_s;
   logic                      maj;

   state_e                    state_r, state_n;
   logic [CNT_W-1:0]          cnt_r, cnt_n;
   logic [IDX_W-1:0]          idx_r, idx_n;
   logic [UART_DATA_BITS-1:0] shift_r, shift_n;
   logic                      deliver_s;
   logic                      ferr_s;
   logic                      ovr_set_s;

   logic [7:0]                data_r, data_n;
   logic                      valid_r, valid_n;
   logic                      ferr_r;
   logic                      ovr_r, ovr_n;
   logic                      busy_r;

   cm_sync_maj u_sync (
      .clk  (clk),
      .rst  (rst),
      .rx_i (rx_i),
      .rx_s (rx_s),
      .maj  (maj)
   );

   // Framing FSM: start qualification, mid-bit data sampling, stop check.
   always_comb begin
      state_n   = state_r;
      cnt_n     = cnt_r;
      idx_n     = idx_r;
      shift_n   = shift_r;
      deliver_s = 1'b0;
      ferr_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               cnt_n   = CNT_ZERO;
            end else begin
               state_n = IDLE;
            end
         end
         START: begin
            if (cnt_r == CNT_HALF) begin
               cnt_n = CNT_ZERO;
               idx_n = IDX_ZERO;
               if (maj) begin
                  state_n = IDLE;
               end else begin
                  state_n = DATA;
               end
            end else begin
               cnt_n = cnt_r + CNT_ONE;
            end
         end
         DATA: begin
            if (cnt_r == CNT_LAST) begin
               cnt_n   = CNT_ZERO;
               shift_n = {maj, shift_r[UART_DATA_BITS-1:1]};
               if (idx_r == IDX_LAST) begin
                  state_n = STOP;
               end else begin
                  idx_n = idx_r + IDX_ONE;
               end
            end else begin
               cnt_n = cnt_r + CNT_ONE;
            end
         end
         STOP: begin
            if (cnt_r == CNT_LAST) begin
               cnt_n = CNT_ZERO;
               if (maj) begin
                  deliver_s = 1'b1;
                  state_n   = IDLE;
               end else begin
                  ferr_s  = 1'b1;
                  state_n = WAIT_HI;
               end
            end else begin
               cnt_n = cnt_r + CNT_ONE;
            end
         end
         WAIT_HI: begin
            // A held break yields one error: wait here until the line recovers.
            if (rx_s) begin
               state_n = IDLE;
            end else begin
               state_n = WAIT_HI;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = CNT_ZERO;
         end
      endcase
   end

   // Output register update: handshake, delivery and overrun bookkeeping.
   always_comb begin
      data_n    = data_r;
      valid_n   = valid_r;
      ovr_set_s = 1'b0;
      if (valid_r && ready_i) begin
         valid_n = 1'b0;
      end else begin
         valid_n = valid_r;
      end
      if (deliver_s) begin
         if (!valid_r || ready_i) begin
            data_n  = shift_r;
            valid_n = 1'b1;
         end else begin
            ovr_set_s = 1'b1;
         end
      end else begin
         data_n = data_r;
      end
      ovr_n = (ovr_r & ~ovr_clr_i) | ovr_set_s;
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         idx_r   <= IDX_ZERO;
         shift_r <= {UART_DATA_BITS{1'b0}};
         data_r  <= 8'h00;
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         ovr_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         idx_r   <= idx_n;
         shift_r <= shift_n;
         data_r  <= data_n;
         valid_r <= valid_n;
         ferr_r  <= ferr_s;
         ovr_r   <= ovr_n;
         busy_r  <= (state_n != IDLE);
      end
   end

   assign data_o      = data_r;
   assign valid_o     = valid_r;
   assign frame_err_o = ferr_r;
   assign overrun_o   = ovr_r;
   assign busy_o      = busy_r;

endmodule

// File: tb/tb_cm_uart_rx.sv
// Directed bench for cm_uart_rx at 8 clocks per bit with a byte scoreboard
// checked on every valid/ready transfer.
module tb_cm_uart_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;
   logic       frame_err_o;
   logic       overrun_o;
   logic       ovr_clr_i;
   logic       busy_o;

   int         n_vec = 0;
   int         n_err = 0;
   int         ferr_cnt = 0;
   int         vld_cnt = 0;
   logic       vld_prev = 1'b0;
   logic [7:0] sb_q[$];

   always #5 clk = ~clk;

   cm_uart_rx #(.CLKS_PER_BIT(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_i        (rx_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o),
      .ovr_clr_i   (ovr_clr_i),
      .busy_o      (busy_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every transfer must match the oldest expected byte.
   always @(negedge clk) begin
      if (frame_err_o === 1'b1) ferr_cnt++;
      if (valid_o === 1'b1 && vld_prev !== 1'b1) vld_cnt++;
      vld_prev = valid_o;
      if (valid_o === 1'b1 && ready_i === 1'b1 && rst === 1'b0) begin
         n_vec++;
         if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL xfer_unexpected: observed %0h expected none", data_o);
         end else begin
            automatic logic [7:0] exp_b = sb_q.pop_front();
            assert (data_o === exp_b) else begin
               n_err++;
               $error("FAIL xfer_data: observed %0h expected %0h", data_o, exp_b);
            end
         end
      end
   end

   task automatic idle(input int n);
      rx_i = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one 8N1 frame, entered and left 1 time unit after a rising edge.
   task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch,
                             input bit rdy_pulse, input bit rst_pulse);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         for (int j = 0; j < 8; j++) begin
            rx_i = bits[k];
            if (glitch && k >= 1 && k <= 8 && j == 3) rx_i = ~bits[k];
            if (rdy_pulse && k == 9 && j == 6) ready_i = 1'b1;
            if (rdy_pulse && k == 9 && j == 7) ready_i = 1'b0;
            if (rst_pulse && k == 5 && j == 0) rst = 1'b1;
            if (rst_pulse && k == 5 && j == 1) rst = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      rx_i = 1'b1;
   endtask

   initial begin
      int f0, v0;
      rst = 1'b1; rx_i = 1'b1; ready_i = 1'b0; ovr_clr_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", data_o, 8'h00);
      check("rst_valid", valid_o, 1'b0);
      check("rst_ferr", frame_err_o, 1'b0);
      check("rst_ovr", overrun_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      rst = 1'b0;
      idle(5);

      // Basic receive with the core always ready.
      ready_i = 1'b1;
      v0 = vld_cnt; f0 = ferr_cnt;
      sb_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      check("basic_data", data_o, 8'hA5);
      check("basic_valid_low", valid_o, 1'b0);
      check("basic_vld_pulses", vld_cnt - v0, 1);
      check("basic_ferr", ferr_cnt - f0, 0);
      check("basic_ovr", overrun_o, 1'b0);

      // Back-pressure: second byte dropped, overrun sticky until cleared.
      ready_i = 1'b0;
      sb_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      check("bp_first_valid", valid_o, 1'b1);
      check("bp_first_data", data_o, 8'h3C);
      check("bp_first_ovr", overrun_o, 1'b0);
      send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      check("bp_hold_data", data_o, 8'h3C);
      check("bp_ovr_set", overrun_o, 1'b1);
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      check("bp_valid_drop", valid_o, 1'b0);
      check("bp_ovr_sticky", overrun_o, 1'b1);
      ovr_clr_i = 1'b1;
      @(posedge clk); #1;
      ovr_clr_i = 1'b0;
      check("bp_ovr_clr", overrun_o, 1'b0);

      // Coincident accept: ready pulses exactly in the delivery cycle.
      sb_q.push_back(8'h22);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      sb_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
      check("coin_data", data_o, 8'h11);
      check("coin_valid", valid_o, 1'b1);
      check("coin_ovr", overrun_o, 1'b0);
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      check("coin_drained", valid_o, 1'b0);

      // Short low glitch is rejected as a false start.
      v0 = vld_cnt;
      rx_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      idle(20);
      check("glitch_busy", busy_o, 1'b0);
      check("glitch_no_valid", vld_cnt - v0, 0);

      // Stop bit low: single error pulse, no byte.
      v0 = vld_cnt; f0 = ferr_cnt;
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(10);
      check("ferr_pulses", ferr_cnt - f0, 1);
      check("ferr_no_valid", vld_cnt - v0, 0);
      check("ferr_ferr_low", frame_err_o, 1'b0);

      // Held break of 40 bit times, then a clean byte.
      f0 = ferr_cnt;
      rx_i = 1'b0;
      repeat (320) @(posedge clk);
      #1;
      idle(20);
      check("break_pulses", ferr_cnt - f0, 1);
      check("break_busy", busy_o, 1'b0);
      ready_i = 1'b1;
      sb_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      check("after_break_data", data_o, 8'h81);

      // Reset during bit 4 of 0xF0 abandons the frame.
      v0 = vld_cnt;
      send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(4);
      check("rstmid_data", data_o, 8'h00);
      check("rstmid_valid", valid_o, 1'b0);
      check("rstmid_busy", busy_o, 1'b0);
      check("rstmid_ovr", overrun_o, 1'b0);
      check("rstmid_no_valid", vld_cnt - v0, 0);
      sb_q.push_back(8'h0F);
      send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      check("rstmid_next_data", data_o, 8'h0F);

      // One-cycle inverted glitch in every data bit is voted out.
      sb_q.push_back(8'h96);
      send_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(4);
      check("noise_data", data_o, 8'h96);
      check("noise_ovr", overrun_o, 1'b0);
      check("sb_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cm_uart_rx.md
Name: cm_uart_rx

Overview:
- Serial command receiver for the tt_um_cm_1 core; the core's upstream stage.
- Takes the raw asynchronous UART line from a dedicated input pin (ui_in[0]) and deframes 8N1 characters.
- Presents each received byte to the core through a valid/ready handshake.
- Reports framing errors and overruns so the core can flag a bad command stream.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per UART bit (10 MHz / 115200); legal range 8..65535.
- CNT_W, $clog2(CLKS_PER_BIT), bit-counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_i  in  1  asynchronous UART line, idle high
- data_o  out  8  received byte, LSB-first deframed
- valid_o  out  1  data_o holds an unconsumed byte
- ready_i  in  1  core accepts data_o this cycle
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- overrun_o  out  1  sticky: byte dropped because the previous byte was unconsumed
- ovr_clr_i  in  1  clears overrun_o
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high. While rst=1 on an edge, every register takes its reset value.
- Reset values: state=IDLE, data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0. The sync flops and the 3-sample history reset to 1 (line idle).
- Reset mid-frame: abandons the frame; no partial byte is ever emitted.
- Input sync: rx_i passes through 2 flops giving rx_s. A 3-bit shift register of rx_s gives maj = majority of the last 3 rx_s samples.
- IDLE: when rx_s=0, go to START with cnt=0.
- START: cnt increments each cycle. At cnt == CLKS_PER_BIT/2-1, sample maj.
  - maj=1: false start, return to IDLE.
  - maj=0: cnt=0, bit_idx=0, go to DATA.
- DATA: at cnt == CLKS_PER_BIT-1, shift maj into the shift register MSB (LSB-first reception) and set cnt=0. After bit_idx 7 go to STOP; otherwise bit_idx increments.
- STOP: at cnt == CLKS_PER_BIT-1, sample maj.
  - maj=1: deliver the byte (see Output), go to IDLE.
  - maj=0: frame_err_o=1 for exactly the next cycle, byte discarded, go to WAIT_HI.
- WAIT_HI: stay until rx_s=1, then go to IDLE. A held break therefore produces one frame_err only.
- Output: delivery updates data_o and valid_o in the cycle after the stop-sample cycle.
  - Latency from the stop-bit midpoint at rx_s to valid_o is 1 cycle.
  - Total latency rx_i to rx_s is 2 cycles.
- Handshake: transfer happens when valid_o & ready_i. valid_o drops the next cycle unless a delivery coincides.
- Delivery cases:
  - Delivery with valid_o=0: load data_o, set valid_o=1.
  - Delivery with valid_o=1 and ready_i=1 in the same cycle: load the new byte, valid_o stays 1, no overrun.
  - Delivery with valid_o=1 and ready_i=0: new byte dropped, data_o unchanged, overrun_o set.
- data_o is stable while valid_o=1 and not accepted.
- overrun_o: cleared by ovr_clr_i. If ovr_clr_i and a new overrun occur in the same cycle, set wins.
- ready_i while valid_o=0 is ignored.
- busy_o = (state != IDLE), registered with the state.

Decomposition:
- Package cm_pkg:
  - state enum {IDLE, START, DATA, STOP, WAIT_HI}.
  - UART_DATA_BITS=8.
  - Default CLKS_PER_BIT.
- Sub-module cm_sync_maj: 2-flop synchroniser plus the 3-sample majority filter (in rx_i, out rx_s and maj). Reused for the core's other ui_in pins.
- FSM, counters and output register stay in cm_uart_rx.

Test Plan:
- Basic receive, CLKS_PER_BIT=8: send 0xA5 with ready_i=1 → valid_o high 1 cycle, data_o=0xA5, frame_err_o=0, overrun_o=0.
- Back-pressure, ready_i=0: send 0x3C then 0x7E → data_o stays 0x3C, overrun_o=1. Assert ready_i → transfer 0x3C. ovr_clr_i → overrun_o=0.
- Coincident accept: ready_i rises in the exact cycle 0x11 is delivered over a held 0x22 → data_o=0x11, valid_o=1, overrun_o=0.
- Glitch and framing:
  - 2-cycle low pulse on rx_i → returns to IDLE, no valid_o.
  - Frame 0x55 with stop bit low → single frame_err_o pulse, no valid_o.
  - Line held low 40 bits → exactly one frame_err_o; next 0x81 received correctly.
- Reset mid-frame: rst=1 for 1 cycle during bit 4 of 0xF0 → all outputs 0, busy_o=0. Subsequent 0x0F received correctly.
- Majority noise: 1-cycle inverted glitch at the midpoint of each data bit of 0x96 → data_o=0x96.
